// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the returned word into the IF/ID register.
module fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_a,
    input  logic [31:0]       imem_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    output logic [31:0]       pc,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc_plus4,
    output logic              id_valid,
    output logic              fault,
    output logic [15:0]       fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic        in_range;
    logic        redirect;
    logic        squash;

    assign pc_plus4 = pc_q + 32'd4;
    assign in_range = (pc_q[1:0] == 2'b00)
                   && (pc_q[31:ADDR_W+2] == '0);
    assign redirect = jump | branch_taken;
    assign squash   = redirect | flush;
    assign imem_a   = pc_q[ADDR_W+1:2];

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        if (fault_q) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
        end else if (squash) begin
            // A redirect overrides stall; a bare flush advances unless stalled.
            valid_d = 1'b0;
            instr_d = 32'h0;
            if (jump)
                pc_d = jump_target;
            else if (branch_taken)
                pc_d = branch_target;
            else if (!stall)
                pc_d = pc_plus4;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (in_range) begin
            pc_d    = pc_plus4;
            instr_d = imem_rd;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            if (cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end else begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            instr_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign id_instr    = instr_q;
    assign id_pc_plus4 = pcp4_q;
    assign id_valid    = valid_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational imem model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, id_instr, id_pc_plus4;
    logic        id_valid, fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_a];

    fetch_unit #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_a(imem_a), .imem_rd(imem_rd),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc(pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid), .fault(fault), .fetch_count(fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        jump = 1; jump_target = 32'h80;
        step();
        reset = 1;
        step();
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++; $display("FAIL reset_pc got %h want 0", pc);
        end
        n_vec++;
        if ({id_instr, id_pc_plus4} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_ifid got %h/%h want 0/0", id_instr, id_pc_plus4);
        end
        n_vec++;
        if ({id_valid, fault, fetch_count} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_flags got v%b f%b c%0d want 0/0/0",
                     id_valid, fault, fetch_count);
        end
        reset = 0;
        clear_ctl();
    endtask

    task automatic test_sequential();
        logic [31:0] ei [3];
        ei[0] = 32'h20020005; ei[1] = 32'h2003000c; ei[2] = 32'h2067fff7;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (imem_a !== 6'(i)) begin
                n_err++; $display("FAIL seq_imem_a[%0d] got %h want %h", i, imem_a, i);
            end
            step();
            n_vec++;
            if (pc !== 32'(4 * (i + 1)) || id_instr !== ei[i]
                || id_pc_plus4 !== 32'(4 * (i + 1)) || id_valid !== 1'b1) begin
                n_err++;
                $display("FAIL seq[%0d] got pc=%h ins=%h p4=%h v=%b want %h/%h/%h/1",
                         i, pc, id_instr, id_pc_plus4, id_valid,
                         4 * (i + 1), ei[i], 4 * (i + 1));
            end
        end
        n_vec++;
        if (fetch_count !== 16'd3) begin
            n_err++; $display("FAIL seq_count got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (pc !== 32'h8 || id_instr !== 32'h2003000c
                || id_pc_plus4 !== 32'h8 || fetch_count !== 16'd2
                || id_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall[%0d] got pc=%h ins=%h p4=%h c=%0d v=%b want 8/2003000c/8/2/1",
                         i, pc, id_instr, id_pc_plus4, fetch_count, id_valid);
            end
        end
        stall = 0;
        step();
        n_vec++;
        if (id_instr !== 32'h2067fff7 || pc !== 32'hC || fetch_count !== 16'd3) begin
            n_err++;
            $display("FAIL stall_release got ins=%h pc=%h c=%0d want 2067fff7/c/3",
                     id_instr, pc, fetch_count);
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(); step(); step();
        jump = 1; jump_target = 32'h3C;
        step();
        n_vec++;
        if (pc !== 32'h3C || id_valid !== 1'b0 || id_instr !== 32'h0
            || id_pc_plus4 !== 32'hC || fetch_count !== 16'd3) begin
            n_err++;
            $display("FAIL jump1 got pc=%h v=%b ins=%h p4=%h c=%0d want 3c/0/0/c/3",
                     pc, id_valid, id_instr, id_pc_plus4, fetch_count);
        end
        jump_target = 32'h44;
        step();
        n_vec++;
        if (pc !== 32'h44 || id_valid !== 1'b0 || id_pc_plus4 !== 32'hC) begin
            n_err++;
            $display("FAIL jump2 got pc=%h v=%b p4=%h want 44/0/c",
                     pc, id_valid, id_pc_plus4);
        end
        jump = 0;
        n_vec++;
        if (imem_a !== 6'h11) begin
            n_err++; $display("FAIL jump_imem_a got %h want 11", imem_a);
        end
        step();
        n_vec++;
        if (id_instr !== 32'hac020054 || id_pc_plus4 !== 32'h48
            || id_valid !== 1'b1 || pc !== 32'h48 || fetch_count !== 16'd4) begin
            n_err++;
            $display("FAIL jump_target got ins=%h p4=%h v=%b pc=%h c=%0d want ac020054/48/1/48/4",
                     id_instr, id_pc_plus4, id_valid, pc, fetch_count);
        end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        step();
        jump = 1; jump_target = 32'h40;
        branch_taken = 1; branch_target = 32'h20;
        stall = 1;
        step();
        n_vec++;
        if (pc !== 32'h40 || id_valid !== 1'b0 || id_instr !== 32'h0) begin
            n_err++;
            $display("FAIL jump_branch_stall got pc=%h v=%b ins=%h want 40/0/0",
                     pc, id_valid, id_instr);
        end
        jump = 0;
        step();
        n_vec++;
        if (pc !== 32'h20 || id_valid !== 1'b0 || fetch_count !== 16'd1) begin
            n_err++;
            $display("FAIL branch_stall got pc=%h v=%b c=%0d want 20/0/1",
                     pc, id_valid, fetch_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step();
        flush = 1;
        step();
        n_vec++;
        if (pc !== 32'h8 || id_valid !== 1'b0 || id_instr !== 32'h0
            || id_pc_plus4 !== 32'h4 || fetch_count !== 16'd1) begin
            n_err++;
            $display("FAIL flush got pc=%h v=%b ins=%h p4=%h c=%0d want 8/0/0/4/1",
                     pc, id_valid, id_instr, id_pc_plus4, fetch_count);
        end
        stall = 1;
        step();
        n_vec++;
        if (pc !== 32'h8 || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall got pc=%h v=%b want 8/0", pc, id_valid);
        end
        flush = 0; stall = 0;
        step();
        n_vec++;
        if (id_instr !== 32'h2067fff7 || id_valid !== 1'b1 || fetch_count !== 16'd2) begin
            n_err++;
            $display("FAIL flush_resume got ins=%h v=%b c=%0d want 2067fff7/1/2",
                     id_instr, id_valid, fetch_count);
        end
    endtask

    task automatic test_fault();
        do_reset();
        step();
        branch_taken = 1; branch_target = 32'h102;
        step();
        n_vec++;
        if (pc !== 32'h102 || id_valid !== 1'b0 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_redirect got pc=%h v=%b f=%b want 102/0/0",
                     pc, id_valid, fault);
        end
        branch_taken = 0;
        step();
        n_vec++;
        if (fault !== 1'b1 || id_valid !== 1'b0 || pc !== 32'h102
            || fetch_count !== 16'd1) begin
            n_err++;
            $display("FAIL fault_raise got f=%b v=%b pc=%h c=%0d want 1/0/102/1",
                     fault, id_valid, pc, fetch_count);
        end
        jump = 1; jump_target = 32'h0;
        step(); step();
        n_vec++;
        if (fault !== 1'b1 || pc !== 32'h102 || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fault_sticky got f=%b pc=%h v=%b want 1/102/0",
                     fault, pc, id_valid);
        end
        clear_ctl();
        reset = 1;
        step();
        reset = 0;
        n_vec++;
        if (fault !== 1'b0 || pc !== 32'h0 || fetch_count !== 16'd0) begin
            n_err++;
            $display("FAIL fault_clear got f=%b pc=%h c=%0d want 0/0/0",
                     fault, pc, fetch_count);
        end
        jump = 1; jump_target = 32'h100;
        step();
        jump = 0;
        step();
        n_vec++;
        if (fault !== 1'b1 || pc !== 32'h100) begin
            n_err++;
            $display("FAIL fault_range got f=%b pc=%h want 1/100", fault, pc);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int b = 0; b < 1025; b++) begin
            for (int i = 0; i < 64; i++) step();
            jump = 1; jump_target = 32'h0;
            step();
            jump = 0;
            if (b == 1022) begin
                n_vec++;
                if (fetch_count !== 16'hFFC0) begin
                    n_err++;
                    $display("FAIL sat_pre got %h want ffc0", fetch_count);
                end
            end
            if (b == 1023) begin
                n_vec++;
                if (fetch_count !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL sat_edge got %h want ffff", fetch_count);
                end
            end
        end
        n_vec++;
        if (fetch_count !== 16'hFFFF || fault !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL sat_hold got c=%h f=%b pc=%h want ffff/0/0",
                     fetch_count, fault, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'h20020005;
        mem[1]  = 32'h2003000c;
        mem[2]  = 32'h2067fff7;
        mem[17] = 32'hac020054;
        reset = 1;
        clear_ctl();
        step();
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_redirect_priority();
        test_flush();
        test_fault();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
